jpeg_mcu_code_arbiter: RTL and testbench
========================================

Name: jpeg_mcu_code_arbiter

Overview:
- Collects Huffman code words from NUM_CH parallel per-component encoder instances (Y, Cb, Cr, ...).
- Buffers them per channel and emits one serial code stream in JPEG MCU interleave order: Y blocks, then Cb, then Cr.
- Sits between the per-component encoders and the bit packer / byte stuffer.
- Supports 4:4:4 mode (1 Y block per MCU) and 4:2:0 mode (4 Y blocks per MCU), with valid/ready backpressure on every side.

Parameters:
- NUM_CH, 3, number of component channels; channel 0 is luminance.
- CODE_W, 16, Huffman code word width.
- LEN_W, 8, code length field width.
- FIFO_DEPTH, 16, entries per channel FIFO; power of two, at least 2.
- MCU_CNT_W, 16, width of the MCU counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mode_420  in  1  0 = 4:4:4, 1 = 4:2:0; latched at each MCU start.
- ch_valid  in  NUM_CH  per-channel code word valid.
- ch_ready  out  NUM_CH  per-channel accept; equals that channel's FIFO not full.
- ch_code  in  NUM_CH*CODE_W  packed code words, channel i at [i*CODE_W +: CODE_W].
- ch_len  in  NUM_CH*LEN_W  packed code lengths.
- ch_last  in  NUM_CH  marks the last code word of an 8x8 block.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_code  out  CODE_W  code word.
- out_len  out  LEN_W  code length.
- out_ch  out  $clog2(NUM_CH) (min 1)  source channel of the beat.
- out_block_end  out  1  beat is the last code word of a block.
- out_mcu_end  out  1  beat is the last code word of the MCU.
- mcu_count  out  MCU_CNT_W  number of completed MCUs; wraps.
- busy  out  1  any FIFO non-empty or out_valid high.

Behaviour:
- Reset values:
  - all FIFOs flushed; ch_ready all 1 on the cycle after reset deasserts.
  - out_valid, out_code, out_len, out_ch, out_block_end, out_mcu_end = 0.
  - mcu_count = 0, busy = 0, cur_ch = 0, blk_cnt = 0.
  - FSM in MCU_START; mode_q = 0.
- Input side:
  - Push into FIFO i when ch_valid[i] && ch_ready[i]; stores {last, len, code} verbatim, zero-length entries included.
  - ch_ready is registered from the FIFO count; push is never attempted while full.
- FSM:
  - MCU_START: latch mode_q <= mode_420; cur_ch = 0; blk_cnt = 0; go to RUN the next cycle.
  - RUN: pop FIFO[cur_ch] when it is non-empty and the output register is free (!out_valid || out_ready). The popped entry loads the output register the same edge.
  - Only FIFO[cur_ch] is ever popped. Other channels keep buffering until their ch_ready drops.
- On a popped entry with last = 1:
  - Case A: cur_ch == 0, mode_q == 1, blk_cnt < 3: blk_cnt++, stay on channel 0.
  - Case B: otherwise, if cur_ch < NUM_CH-1: cur_ch++, blk_cnt = 0.
  - Case C: otherwise, out_mcu_end = 1 on that beat, mcu_count++, FSM goes to MCU_START.
  - out_block_end = 1 on every last = 1 beat.
  - NUM_CH == 1: every block (or every 4th block in 4:2:0) ends the MCU.
- Output hold: out_* stay stable while out_valid && !out_ready.
- Latency: a word pushed at edge t appears with out_valid at edge t+2 at the earliest. There is no FIFO fall-through.
- Throughput: 1 beat/cycle sustained within an MCU. Each MCU boundary costs one MCU_START bubble cycle.
- Simultaneous push and pop on the same FIFO are both legal in one cycle; the count is unchanged.
- mode_420 changes mid-MCU have no effect until the next MCU_START.
- A reset mid-MCU discards all buffered and registered data; no partial beat appears after reset.

Decomposition:
- Package jpeg_enc_pkg:
  - CODE_W and LEN_W defaults.
  - code entry struct {last, len, code}.
  - FSM state enum {MCU_START, RUN}.
  - constants CH_Y = 0 and Y_BLOCKS_420 = 4.
- Sub-module jpeg_code_fifo:
  - synchronous FIFO, parametrised width and depth.
  - outputs full, empty, count.
  - one instance per channel via generate.

Test Plan:
- 4:4:4, NUM_CH = 3, out_ready = 1:
  - stimulus: Y block codes 0x0001, 0x0002 (last); Cb 0x0010 (last); Cr 0x0100 (last), all pushed at once.
  - required: out_code sequence 0x0001, 0x0002, 0x0010, 0x0100; out_ch 0, 0, 1, 2; out_block_end 0, 1, 1, 1; out_mcu_end only on 0x0100; mcu_count = 1.
- 4:2:0:
  - stimulus: four single-word Y blocks 0xA0..0xA3 plus one Cb and one Cr block.
  - required: out order A0, A1, A2, A3, Cb, Cr; blk_cnt reaches 3 before the switch; one mcu_out_end.
- Backpressure:
  - stimulus: hold out_ready = 0 for 10 cycles with out_valid high.
  - required: out_code stable, no beat lost or duplicated; FIFO 0 fills and ch_ready[0] = 0 after 16 pushes; resumes in order when out_ready = 1.
- Out-of-order arrival:
  - stimulus: Cr block fully pushed before any Y data.
  - required: nothing emitted until Y and Cb complete; Cr emitted last.
- Mode change:
  - stimulus: mode_420 toggled 1 to 0 during the second Y block.
  - required: the current MCU still takes 4 Y blocks; the next MCU takes 1.
- Reset mid-MCU:
  - stimulus: assert reset after 2 of 3 blocks are emitted.
  - required: next cycle out_valid = 0, mcu_count = 0, busy = 0; a fresh MCU afterwards starts at channel 0.

Source files
------------

// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG entropy-coding datapath.
package jpeg_enc_pkg;

    localparam int CODE_W_DEF   = 16;
    localparam int LEN_W_DEF    = 8;

    // Channel 0 carries luminance; 4:2:0 packs four Y blocks per MCU.
    localparam int CH_Y         = 0;
    localparam int Y_BLOCKS_420 = 4;

    // One buffered Huffman code word, stored exactly as received.
    typedef struct packed {
        logic                  last;
        logic [LEN_W_DEF-1:0]  len;
        logic [CODE_W_DEF-1:0] code;
    } code_entry_t;

    typedef enum logic [0:0] {
        MCU_START = 1'b0,
        RUN       = 1'b1
    } mcu_state_e;

endpackage

// File: rtl/jpeg_code_fifo.sv
// Per-channel synchronous code word FIFO.
// An entry only becomes poppable one cycle after the cycle it was written,
// so a word can never pass straight from input to output (no fall-through).
// o_full/o_count track every stored entry; o_empty tracks poppable entries.
module jpeg_code_fifo
    import jpeg_enc_pkg::*;
#(
    parameter  int WIDTH = 1 + LEN_W_DEF + CODE_W_DEF,
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_rd_avail;
    logic             r_full;
    logic             r_push_d;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_avail_nxt;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && (r_rd_avail != '0);

    // Next occupancy: simultaneous push and pop leave both counts unchanged.
    always_comb begin
        w_count_nxt = r_count;
        w_avail_nxt = r_rd_avail;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
        if (r_push_d && !w_pop) begin
            w_avail_nxt = r_rd_avail + CW'(1);
        end else if (!r_push_d && w_pop) begin
            w_avail_nxt = r_rd_avail - CW'(1);
        end
    end

    // Pointer, occupancy and registered-full bookkeeping.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_avail <= '0;
            r_full     <= 1'b0;
            r_push_d   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_rd_avail <= w_avail_nxt;
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_push_d   <= w_push;
        end
    end

    // Storage array; contents need no reset since the counts gate every read.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_rd_avail == '0);
    assign o_count = r_count;

endmodule

// File: rtl/jpeg_mcu_code_arbiter.sv
// Merges per-component Huffman code streams into one MCU-interleaved stream:
// all Y blocks of the MCU, then Cb, then Cr (generally channel 0..NUM_CH-1).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// MCU_START | one bubble cycle: latch 4:2:0 mode, rewind to channel 0
// RUN       | drain FIFO[cur_ch] block by block until the MCU completes
module jpeg_mcu_code_arbiter
    import jpeg_enc_pkg::*;
#(
    parameter  int NUM_CH     = 3,
    parameter  int CODE_W     = CODE_W_DEF,
    parameter  int LEN_W      = LEN_W_DEF,
    parameter  int FIFO_DEPTH = 16,
    parameter  int MCU_CNT_W  = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_mode_420,
    input  logic [NUM_CH-1:0]        i_ch_valid,
    output logic [NUM_CH-1:0]        o_ch_ready,
    input  logic [NUM_CH*CODE_W-1:0] i_ch_code,
    input  logic [NUM_CH*LEN_W-1:0]  i_ch_len,
    input  logic [NUM_CH-1:0]        i_ch_last,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [CODE_W-1:0]        o_out_code,
    output logic [LEN_W-1:0]         o_out_len,
    output logic [CH_W-1:0]          o_out_ch,
    output logic                     o_out_block_end,
    output logic                     o_out_mcu_end,
    output logic [MCU_CNT_W-1:0]     o_mcu_count,
    output logic                     o_busy
);

    localparam int               ENT_W    = 1 + LEN_W + CODE_W;
    localparam int               CNT_W    = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  Y_CH     = CH_W'(CH_Y);
    localparam logic [1:0]       BLK_LAST = 2'(Y_BLOCKS_420 - 1);

    mcu_state_e                r_state;
    logic                      r_mode_q;
    logic [CH_W-1:0]           r_cur_ch;
    logic [1:0]                r_blk_cnt;
    logic [MCU_CNT_W-1:0]      r_mcu_count;

    logic                      r_out_valid;
    logic [CODE_W-1:0]         r_out_code;
    logic [LEN_W-1:0]          r_out_len;
    logic [CH_W-1:0]           r_out_ch;
    logic                      r_out_block_end;
    logic                      r_out_mcu_end;

    logic [ENT_W-1:0]          w_fifo_data  [NUM_CH];
    logic [CNT_W-1:0]          w_fifo_count [NUM_CH];
    logic [NUM_CH-1:0]         w_fifo_full;
    logic [NUM_CH-1:0]         w_fifo_empty;
    logic [NUM_CH-1:0]         w_fifo_busy;
    logic [NUM_CH-1:0]         w_push;
    logic [NUM_CH-1:0]         w_pop_ch;

    logic [ENT_W-1:0]          w_head;
    logic                      w_head_empty;
    logic                      w_head_last;
    logic [LEN_W-1:0]          w_head_len;
    logic [CODE_W-1:0]         w_head_code;
    logic                      w_out_free;
    logic                      w_pop;
    logic                      w_more_y;
    logic                      w_more_ch;
    logic                      w_mcu_done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_push[g]      = i_ch_valid[g] && !w_fifo_full[g];
        assign w_pop_ch[g]    = w_pop && (r_cur_ch == CH_W'(g));
        assign w_fifo_busy[g] = (w_fifo_count[g] != '0);

        jpeg_code_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_push  (w_push[g]),
            .i_data  ({i_ch_last[g], i_ch_len[g*LEN_W +: LEN_W], i_ch_code[g*CODE_W +: CODE_W]}),
            .i_pop   (w_pop_ch[g]),
            .o_data  (w_fifo_data[g]),
            .o_full  (w_fifo_full[g]),
            .o_empty (w_fifo_empty[g]),
            .o_count (w_fifo_count[g])
        );
    end

    // Head-of-line mux: only the current channel's FIFO is ever considered.
    always_comb begin
        w_head       = '0;
        w_head_empty = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_cur_ch == CH_W'(k)) begin
                w_head       = w_fifo_data[k];
                w_head_empty = w_fifo_empty[k];
            end
        end
    end

    assign w_head_last = w_head[ENT_W-1];
    assign w_head_len  = w_head[CODE_W +: LEN_W];
    assign w_head_code = w_head[CODE_W-1:0];

    assign w_out_free  = !r_out_valid || i_out_ready;
    assign w_pop       = (r_state == RUN) && !w_head_empty && w_out_free;

    // Block-boundary decisions for a popped last word.
    assign w_more_y    = (r_cur_ch == Y_CH) && r_mode_q && (r_blk_cnt < BLK_LAST);
    assign w_more_ch   = (r_cur_ch != LAST_CH);
    assign w_mcu_done  = w_pop && w_head_last && !w_more_y && !w_more_ch;

    // MCU sequencing: channel/block position and completed-MCU counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= MCU_START;
            r_mode_q    <= 1'b0;
            r_cur_ch    <= '0;
            r_blk_cnt   <= '0;
            r_mcu_count <= '0;
        end else begin
            case (r_state)
                MCU_START: begin
                    r_mode_q  <= i_mode_420;
                    r_cur_ch  <= '0;
                    r_blk_cnt <= '0;
                    r_state   <= RUN;
                end
                RUN: begin
                    if (w_pop && w_head_last) begin
                        if (w_more_y) begin
                            r_blk_cnt <= r_blk_cnt + 2'd1;
                        end else if (w_more_ch) begin
                            r_cur_ch  <= r_cur_ch + CH_W'(1);
                            r_blk_cnt <= '0;
                        end else begin
                            r_mcu_count <= r_mcu_count + MCU_CNT_W'(1);
                            r_state     <= MCU_START;
                        end
                    end
                end
                default: r_state <= MCU_START;
            endcase
        end
    end

    // Output register: loads on pop, holds while stalled, drops when drained.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_valid     <= 1'b0;
            r_out_code      <= '0;
            r_out_len       <= '0;
            r_out_ch        <= '0;
            r_out_block_end <= 1'b0;
            r_out_mcu_end   <= 1'b0;
        end else if (w_pop) begin
            r_out_valid     <= 1'b1;
            r_out_code      <= w_head_code;
            r_out_len       <= w_head_len;
            r_out_ch        <= r_cur_ch;
            r_out_block_end <= w_head_last;
            r_out_mcu_end   <= w_mcu_done;
        end else if (i_out_ready) begin
            r_out_valid     <= 1'b0;
        end
    end

    assign o_ch_ready      = ~w_fifo_full;
    assign o_out_valid     = r_out_valid;
    assign o_out_code      = r_out_code;
    assign o_out_len       = r_out_len;
    assign o_out_ch        = r_out_ch;
    assign o_out_block_end = r_out_block_end;
    assign o_out_mcu_end   = r_out_mcu_end;
    assign o_mcu_count     = r_mcu_count;
    assign o_busy          = (|w_fifo_busy) || r_out_valid;

endmodule

// File: tb/tb_jpeg_mcu_code_arbiter.sv
// Self-checking bench for jpeg_mcu_code_arbiter (NUM_CH = 3, default widths).
module tb_jpeg_mcu_code_arbiter;
    import jpeg_enc_pkg::*;

    localparam int NCH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [2:0]  ch_valid = '0;
    logic [2:0]  ch_ready;
    logic [47:0] ch_code = '0;
    logic [23:0] ch_len = '0;
    logic [2:0]  ch_last = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_code;
    logic [7:0]  out_len;
    logic [1:0]  out_ch;
    logic        blk_end;
    logic        mcu_end;
    logic [15:0] mcu_count;
    logic        busy;

    always #5 clk = ~clk;

    jpeg_mcu_code_arbiter #(
        .NUM_CH(3), .CODE_W(16), .LEN_W(8), .FIFO_DEPTH(16), .MCU_CNT_W(16)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_mode_420(mode),
        .i_ch_valid(ch_valid), .o_ch_ready(ch_ready),
        .i_ch_code(ch_code), .i_ch_len(ch_len), .i_ch_last(ch_last),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_code(out_code), .o_out_len(out_len), .o_out_ch(out_ch),
        .o_out_block_end(blk_end), .o_out_mcu_end(mcu_end),
        .o_mcu_count(mcu_count), .o_busy(busy)
    );

    typedef struct packed {
        logic [15:0] code;
        logic [7:0]  len;
        logic [1:0]  ch;
        logic        blk;
        logic        mcu;
    } beat_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] code;
        logic [7:0]  len;
        logic        last;
        logic [15:0] x_code;
        logic [7:0]  x_len;
        logic [1:0]  x_ch;
        logic        x_blk;
        logic        x_mcu;
    } vec_t;

    code_entry_t txq [NCH][$];
    beat_t       expq[$];
    beat_t       rxq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          in_prob = 100;
    int          out_prob = 100;
    bit          hold_pend = 0;
    beat_t       hold_val;
    int          acc [NCH];

    vec_t        tab444 [4];
    vec_t        tab420 [6];

    function automatic beat_t cur_beat();
        return beat_t'({out_code, out_len, out_ch, blk_end, mcu_end});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One cycle: sample outputs at negedge, pick handshakes for the next edge.
    task automatic step();
        code_entry_t dummy;
        @(negedge clk);
        if (hold_pend) begin
            chk("hold_beat", 32'(cur_beat()), 32'(hold_val));
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = ($urandom_range(0, 99) < out_prob);
        if (out_valid && out_ready) rxq.push_back(cur_beat());
        hold_pend = out_valid && !out_ready;
        hold_val  = cur_beat();
        for (int c = 0; c < NCH; c++) begin
            if (txq[c].size() > 0 && $urandom_range(0, 99) < in_prob) begin
                ch_valid[c]          = 1'b1;
                ch_code[c*16 +: 16]  = txq[c][0].code;
                ch_len[c*8 +: 8]     = txq[c][0].len;
                ch_last[c]           = txq[c][0].last;
                if (ch_ready[c]) begin
                    dummy = txq[c].pop_front();
                    acc[c]++;
                end
            end else begin
                ch_valid[c] = 1'b0;
            end
        end
    endtask

    task automatic apply_reset(input logic m);
        @(negedge clk);
        rst = 1'b1;
        mode = m;
        ch_valid = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            txq[c].delete();
            acc[c] = 0;
        end
        expq.delete();
        rxq.delete();
        hold_pend = 0;
    endtask

    // Reference model: an MCU is its Y blocks (1 or 4), then one Cb, then one Cr.
    task automatic add_mcu(input bit m420);
        int          nblk;
        int          nw;
        code_entry_t e;
        beat_t       x;
        for (int c = 0; c < NCH; c++) begin
            nblk = (c == 0 && m420) ? 4 : 1;
            for (int b = 0; b < nblk; b++) begin
                nw = $urandom_range(1, 3);
                for (int w = 0; w < nw; w++) begin
                    e.code = 16'($urandom);
                    e.len  = 8'($urandom_range(0, 16));
                    e.last = (w == nw - 1);
                    txq[c].push_back(e);
                    x.code = e.code;
                    x.len  = e.len;
                    x.ch   = 2'(c);
                    x.blk  = e.last;
                    x.mcu  = e.last && (c == NCH - 1) && (b == nblk - 1);
                    expq.push_back(x);
                end
            end
        end
    endtask

    task automatic load_vec(input vec_t v);
        code_entry_t e;
        beat_t       x;
        e.last = v.last; e.len = v.len; e.code = v.code;
        txq[v.ch].push_back(e);
        x.code = v.x_code; x.len = v.x_len; x.ch = v.x_ch; x.blk = v.x_blk; x.mcu = v.x_mcu;
        expq.push_back(x);
    endtask

    task automatic push_word(input int c, input logic [15:0] code, input logic last, input logic mcu);
        code_entry_t e;
        beat_t       x;
        e.last = last; e.len = code[7:0]; e.code = code;
        txq[c].push_back(e);
        x.code = code; x.len = code[7:0]; x.ch = 2'(c); x.blk = last; x.mcu = mcu;
        expq.push_back(x);
    endtask

    task automatic run_all(input int budget, input int toggle_at, input string name);
        int cyc;
        cyc = 0;
        while (rxq.size() < expq.size() && cyc < budget) begin
            step();
            cyc++;
            if (toggle_at >= 0 && rxq.size() >= toggle_at) mode = 1'b0;
        end
        out_prob = 100;
        repeat (4) step();
        chk({name, "_beat_count"}, 32'(rxq.size()), 32'(expq.size()));
    endtask

    task automatic check_beats(input string name);
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), 32'(rxq[i]), 32'(expq[i]));
        expq.delete();
        rxq.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int m;
        int nm;
        int nb1;
        int cyc;

        tab444[0] = '{2'd0, 16'h0001, 8'd4, 1'b0, 16'h0001, 8'd4, 2'd0, 1'b0, 1'b0};
        tab444[1] = '{2'd0, 16'h0002, 8'd5, 1'b1, 16'h0002, 8'd5, 2'd0, 1'b1, 1'b0};
        tab444[2] = '{2'd1, 16'h0010, 8'd3, 1'b1, 16'h0010, 8'd3, 2'd1, 1'b1, 1'b0};
        tab444[3] = '{2'd2, 16'h0100, 8'd7, 1'b1, 16'h0100, 8'd7, 2'd2, 1'b1, 1'b1};
        tab420[0] = '{2'd0, 16'h00A0, 8'd2, 1'b1, 16'h00A0, 8'd2, 2'd0, 1'b1, 1'b0};
        tab420[1] = '{2'd0, 16'h00A1, 8'd2, 1'b1, 16'h00A1, 8'd2, 2'd0, 1'b1, 1'b0};
        tab420[2] = '{2'd0, 16'h00A2, 8'd2, 1'b1, 16'h00A2, 8'd2, 2'd0, 1'b1, 1'b0};
        tab420[3] = '{2'd0, 16'h00A3, 8'd2, 1'b1, 16'h00A3, 8'd2, 2'd0, 1'b1, 1'b0};
        tab420[4] = '{2'd1, 16'h00B0, 8'd6, 1'b1, 16'h00B0, 8'd6, 2'd1, 1'b1, 1'b0};
        tab420[5] = '{2'd2, 16'h00C0, 8'd9, 1'b1, 16'h00C0, 8'd9, 2'd2, 1'b1, 1'b1};

        // Reset state
        apply_reset(1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_beat", 32'(cur_beat()), 32'd0);
        chk("rst_mcu_count", 32'(mcu_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ch_ready), 32'h7);
        step();
        chk("rst_ready_after", 32'(ch_ready), 32'h7);

        // 4:4:4 directed table
        apply_reset(1'b0);
        in_prob = 100; out_prob = 100;
        for (int i = 0; i < 4; i++) load_vec(tab444[i]);
        run_all(100, -1, "t444");
        check_beats("t444");
        chk("t444_mcu_count", 32'(mcu_count), 32'd1);
        chk("t444_busy", 32'(busy), 32'd0);

        // 4:2:0 directed table
        apply_reset(1'b1);
        for (int i = 0; i < 6; i++) load_vec(tab420[i]);
        run_all(100, -1, "t420");
        check_beats("t420");
        chk("t420_mcu_count", 32'(mcu_count), 32'd1);

        // Backpressure: fill FIFO 0 behind a stalled output beat
        apply_reset(1'b0);
        in_prob = 100; out_prob = 0;
        push_word(0, 16'h5000, 1'b0, 1'b0);
        step();
        step();
        chk("lat_t0", 32'(out_valid), 32'd0);
        step();
        chk("lat_t1", 32'(out_valid), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 10) begin step(); cyc++; end
        chk("lat_arrive", 32'(out_valid), 32'd1);
        acc[0] = 0;
        for (int i = 1; i <= 16; i++) push_word(0, 16'(16'h5000 + i), (i == 16), 1'b0);
        cyc = 0;
        while (txq[0].size() > 0 && cyc < 60) begin step(); cyc++; end
        chk("bp_pushes", 32'(acc[0]), 32'd16);
        step();
        chk("bp_ready0", 32'(ch_ready[0]), 32'd0);
        repeat (10) step();
        chk("bp_code_held", 32'(out_code), 32'h5000);
        push_word(1, 16'h5100, 1'b1, 1'b0);
        push_word(2, 16'h5200, 1'b1, 1'b1);
        out_prob = 100;
        run_all(200, -1, "bp");
        check_beats("bp");
        chk("bp_mcu_count", 32'(mcu_count), 32'd1);

        // Out-of-order arrival: Cr first, then Y, then Cb
        apply_reset(1'b0);
        in_prob = 100; out_prob = 100;
        push_word(0, 16'h7A00, 1'b1, 1'b0);
        push_word(1, 16'h7B00, 1'b1, 1'b0);
        push_word(2, 16'h7C00, 1'b0, 1'b0);
        push_word(2, 16'h7C01, 1'b1, 1'b1);
        begin
            code_entry_t y_hold [$];
            code_entry_t cb_hold [$];
            y_hold  = txq[0]; txq[0].delete();
            cb_hold = txq[1]; txq[1].delete();
            repeat (20) step();
            chk("ooo_none_early", 32'(rxq.size()), 32'd0);
            chk("ooo_valid_low", 32'(out_valid), 32'd0);
            txq[0] = y_hold;
            repeat (10) step();
            chk("ooo_only_y", 32'(rxq.size()), 32'd1);
            txq[1] = cb_hold;
        end
        run_all(100, -1, "ooo");
        check_beats("ooo");
        chk("ooo_mcu_count", 32'(mcu_count), 32'd1);

        // Mode change mid-MCU: current MCU keeps 4 Y blocks, next takes 1
        apply_reset(1'b1);
        in_prob = 70; out_prob = 80;
        add_mcu(1'b1);
        add_mcu(1'b0);
        nb1 = 0;
        while (!expq[nb1].blk) nb1++;
        run_all(2000, nb1 + 2, "mode");
        check_beats("mode");
        chk("mode_mcu_count", 32'(mcu_count), 32'd2);

        // Reset in the middle of an MCU
        apply_reset(1'b0);
        in_prob = 100; out_prob = 100;
        push_word(0, 16'h0E01, 1'b1, 1'b0);
        push_word(1, 16'h0E02, 1'b1, 1'b0);
        push_word(2, 16'h0E03, 1'b1, 1'b1);
        cyc = 0;
        while (rxq.size() < 2 && cyc < 50) begin step(); cyc++; end
        chk("rmid_progress", 32'(rxq.size()), 32'd2);
        rst = 1'b1;
        ch_valid = '0;
        @(negedge clk);
        chk("rmid_valid", 32'(out_valid), 32'd0);
        chk("rmid_mcu_count", 32'(mcu_count), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) txq[c].delete();
        expq.delete();
        rxq.delete();
        hold_pend = 0;
        add_mcu(1'b0);
        run_all(500, -1, "rmid");
        check_beats("rmid");
        chk("rmid_fresh_count", 32'(mcu_count), 32'd1);

        // Randomized phases against the MCU-order model
        for (int p = 0; p < 4; p++) begin
            m = int'($urandom_range(0, 1));
            apply_reset(m[0]);
            nm = int'($urandom_range(2, 4));
            for (int k = 0; k < nm; k++) add_mcu(m[0]);
            in_prob  = int'($urandom_range(40, 100));
            out_prob = int'($urandom_range(40, 100));
            run_all(4000, -1, "rand");
            check_beats("rand");
            chk("rand_mcu_count", 32'(mcu_count), 32'(nm));
            chk("rand_busy", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
